// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums N consecutive multiplier products and hands the total out over valid/ready
module product_accumulator #(
    parameter int PW = 8,
    parameter int N  = 4,
    parameter int AW = 12,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] prod,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          clear,
    output logic [AW-1:0] sum_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] count,
    output logic          ovf
);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] acc;
    logic [AW:0]   add_full;
    logic          accept;
    logic          last;
    logic          handshake;

    // One extra bit on the add so the carry out of the accumulator is visible for ovf.
    assign add_full  = {1'b0, acc} + {{(AW + 1 - PW){1'b0}}, prod};

    // clear outranks both handshakes, so it also vetoes an accept or a result pickup.
    assign accept    = (state == ACCUM) && in_valid && !clear;
    assign last      = (count == CW'(N - 1));
    assign handshake = (state == DONE) && out_ready && !clear;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: the Nth accept finishes a batch; pickup or clear returns to accumulating.
    always_comb begin
        state_next = state;
        case (state)
            ACCUM: begin
                if (accept && last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (clear || out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    // Handshake outputs depend only on state, so there is no same-cycle turnaround.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM:   in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Datapath: accumulate, capture the batch total, and restart after pickup or clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            sum_out <= '0;
        end else if (clear) begin
            // sum_out deliberately keeps the last completed batch.
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (accept) begin
            acc <= add_full[AW-1:0];
            ovf <= ovf | add_full[AW];
            if (last) begin
                sum_out <= add_full[AW-1:0];
                count   <= CW'(N);
            end else begin
                count <= count + CW'(1);
            end
        end else if (handshake) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end
    end

endmodule
